// File: rtl/csa_sequencer.sv
// Microcode sequencer: next-address selection with a return-address stack.
// Stack errors freeze the sequencer in FAULT until reset.
module csa_sequencer #(
   parameter int ADDR_WIDTH  = 11,
   parameter int STACK_DEPTH = 4,
   parameter int RESET_ADDR  = 0
) (
   input  logic                             CLK,
   input  logic                             RESET,
   input  logic                             ACK,
   input  logic [2:0]                       MODE,
   input  logic [ADDR_WIDTH-1:0]            TARGET,
   input  logic                             COND,
   output logic [ADDR_WIDTH-1:0]            OUT,
   output logic [$clog2(STACK_DEPTH+1)-1:0] DEPTH,
   output logic                             OVERFLOW,
   output logic                             UNDERFLOW,
   output logic                             FAULT
);

   localparam int DW = $clog2(STACK_DEPTH+1);
   localparam logic [DW-1:0]         FULL  = DW'(STACK_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] ONE   = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] RADDR = ADDR_WIDTH'(RESET_ADDR);

   localparam logic [2:0] M_INC = 3'b000;
   localparam logic [2:0] M_JMP = 3'b001;
   localparam logic [2:0] M_BR  = 3'b010;
   localparam logic [2:0] M_CAL = 3'b011;
   localparam logic [2:0] M_RET = 3'b100;

   typedef enum logic {S_RUN, S_FAULT} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] out_q, out_d, inc;
   logic [DW-1:0]         depth_q, depth_d;
   logic                  ovf_q, ovf_d, unf_q, unf_d;
   logic                  push, pop;

   // Shift-register stack: entry 0 is always the top of stack.
   logic [ADDR_WIDTH-1:0] stk_q [STACK_DEPTH];

   assign inc = out_q + ONE;

   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      depth_d = depth_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      push    = 1'b0;
      pop     = 1'b0;
      if (state_q == S_RUN && !ACK) begin
         case (MODE)
            M_INC: out_d = inc;
            M_JMP: out_d = TARGET;
            M_BR:  out_d = COND ? TARGET : inc;
            M_CAL: begin
               if (depth_q < FULL) begin
                  push    = 1'b1;
                  out_d   = TARGET;
                  depth_d = depth_q + 1'b1;
               end else begin
                  ovf_d   = 1'b1;
                  state_d = S_FAULT;
               end
            end
            M_RET: begin
               if (depth_q != '0) begin
                  pop     = 1'b1;
                  out_d   = stk_q[0];
                  depth_d = depth_q - 1'b1;
               end else begin
                  unf_d   = 1'b1;
                  state_d = S_FAULT;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= S_RUN;
         out_q   <= RADDR;
         depth_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         depth_q <= depth_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Contents need no reset: entries are unreachable while depth is 0.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         if (push) begin
            stk_q[0] <= inc;
            for (int i = 1; i < STACK_DEPTH; i++)
               stk_q[i] <= stk_q[i-1];
         end else if (pop) begin
            for (int i = 0; i < STACK_DEPTH-1; i++)
               stk_q[i] <= stk_q[i+1];
         end
      end
   end

   assign OUT       = out_q;
   assign DEPTH     = depth_q;
   assign OVERFLOW  = ovf_q;
   assign UNDERFLOW = unf_q;
   assign FAULT     = (state_q == S_FAULT);

endmodule

// File: tb/tb_csa_sequencer.sv
// Bench for csa_sequencer: directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_csa_sequencer;

   localparam int AW = 11;
   localparam int SD = 4;
   localparam int RA = 0;
   localparam int DW = $clog2(SD+1);
   localparam int AMAX = 1 << AW;

   localparam int INC = 0, JMP = 1, BR = 2, CAL = 3, RET = 4, NOP = 5;

   logic          CLK = 1'b0;
   logic          RESET, ACK, COND;
   logic [2:0]    MODE;
   logic [AW-1:0] TARGET, OUT;
   logic [DW-1:0] DEPTH;
   logic          OVERFLOW, UNDERFLOW, FAULT;

   always #5 CLK = ~CLK;

   csa_sequencer #(
      .ADDR_WIDTH(AW), .STACK_DEPTH(SD), .RESET_ADDR(RA)
   ) dut (
      .CLK(CLK), .RESET(RESET), .ACK(ACK), .MODE(MODE),
      .TARGET(TARGET), .COND(COND), .OUT(OUT), .DEPTH(DEPTH),
      .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW), .FAULT(FAULT)
   );

   int n_chk = 0;
   int n_pass = 0;

   int m_out, m_ovf, m_unf, m_fault;
   int m_stk[$];

   task automatic chk(string nm, int act, int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s got %0h exp %0h", nm, act, exp);
   endtask

   task automatic model(bit rst, bit ack, int mode, int tgt, bit cond);
      if (rst) begin
         m_out = RA; m_stk.delete();
         m_ovf = 0; m_unf = 0; m_fault = 0;
      end else if (!m_fault && !ack) begin
         case (mode)
            INC: m_out = (m_out + 1) % AMAX;
            JMP: m_out = tgt;
            BR:  m_out = cond ? tgt : (m_out + 1) % AMAX;
            CAL: if (m_stk.size() < SD) begin
                    m_stk.push_back((m_out + 1) % AMAX);
                    m_out = tgt;
                 end else begin
                    m_ovf = 1; m_fault = 1;
                 end
            RET: if (m_stk.size() > 0) m_out = m_stk.pop_back();
                 else begin m_unf = 1; m_fault = 1; end
            default: ;
         endcase
      end
   endtask

   task automatic cyc(bit rst, bit ack, int mode, int tgt, bit cond);
      RESET = rst; ACK = ack; MODE = 3'(mode);
      TARGET = AW'(tgt); COND = cond;
      @(posedge CLK);
      model(rst, ack, mode, tgt, cond);
      #1;
      chk("out", int'(OUT), m_out);
      chk("depth", int'(DEPTH), m_stk.size());
      chk("ovf", int'(OVERFLOW), m_ovf);
      chk("unf", int'(UNDERFLOW), m_unf);
      chk("fault", int'(FAULT), m_fault);
   endtask

   task automatic go(int mode, int tgt = 0, bit cond = 0);
      cyc(0, 0, mode, tgt, cond);
   endtask

   initial begin
      RESET = 1; ACK = 0; MODE = 0; TARGET = 0; COND = 0;
      cyc(1, 0, INC, 0, 0);
      chk("rst_out", int'(OUT), 0);
      chk("rst_fault", int'(FAULT), 0);

      // Counting with a 3-cycle stall at 5, then full wrap.
      for (int i = 1; i <= 5; i++) go(INC);
      for (int i = 0; i < 3; i++) cyc(0, 1, INC, 0, 0);
      chk("hold5", int'(OUT), 5);
      go(INC);
      chk("resume6", int'(OUT), 6);
      for (int i = 7; i <= 2048; i++) go(INC);
      chk("wrap0", int'(OUT), 0);

      go(JMP, 'h010);
      go(BR, 'h200, 0);
      chk("br_nt", int'(OUT), 'h011);
      go(JMP, 'h010);
      go(BR, 'h200, 1);
      chk("br_t", int'(OUT), 'h200);
      go(JMP, 'h7FF);
      go(INC);
      chk("jmp_wrap", int'(OUT), 0);

      go(JMP, 'h010);
      go(CAL, 'h100);
      chk("c1", int'(OUT), 'h100); chk("d1", int'(DEPTH), 1);
      go(CAL, 'h300);
      chk("c2", int'(OUT), 'h300); chk("d2", int'(DEPTH), 2);
      go(RET);
      chk("r1", int'(OUT), 'h101); chk("d3", int'(DEPTH), 1);
      go(RET);
      chk("r2", int'(OUT), 'h011); chk("d4", int'(DEPTH), 0);

      for (int i = 0; i < 5; i++) go(CAL, 'h40 * (i + 1));
      chk("ovf_depth", int'(DEPTH), 4);
      chk("ovf_out", int'(OUT), 'h100);
      chk("ovf_flag", int'(OVERFLOW), 1);
      chk("ovf_fault", int'(FAULT), 1);
      for (int i = 0; i < 3; i++) go(INC);
      chk("frozen", int'(OUT), 'h100);
      cyc(1, 0, INC, 0, 0);
      chk("rst2_out", int'(OUT), 0);
      chk("rst2_ovf", int'(OVERFLOW), 0);

      go(RET);
      chk("unf_flag", int'(UNDERFLOW), 1);
      chk("unf_fault", int'(FAULT), 1);
      chk("unf_out", int'(OUT), RA);
      chk("unf_ovf", int'(OVERFLOW), 0);
      cyc(1, 0, INC, 0, 0);
      go(CAL, 'h123);
      cyc(0, 1, CAL, 'h456, 0);
      chk("ack_call", int'(DEPTH), 1);
      chk("ack_out", int'(OUT), 'h123);

      // Reset mid-CALL wins.
      cyc(1, 0, CAL, 'h3AA, 0);
      chk("rst_call", int'(DEPTH), 0);

      for (int i = 0; i < 4000; i++) begin
         bit rst;
         rst = ($urandom_range(0, 199) == 0) ||
               (m_fault != 0 && $urandom_range(0, 7) == 0);
         cyc(rst, $urandom_range(0, 3) == 0, $urandom_range(0, 7),
             $urandom & (AMAX - 1), $urandom_range(0, 1));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/csa_sequencer.md
CSA_SEQUENCER -- requirements
Module: csa_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 11, giving the control-store address width in bits.
REQ-002 SHALL have parameter STACK_DEPTH, default 4, giving the number of return-address stack entries (>=1).
REQ-003 SHALL have parameter RESET_ADDR, default 0, giving the address loaded on reset.
REQ-004 SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port RESET  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port ACK  input  1  stall: 1 = hold all state this cycle, 0 = advance per MODE.
REQ-007 SHALL have port MODE  input  3  next-address command: 000 INC, 001 JUMP, 010 BRANCH, 011 CALL, 100 RET, 101-111 NOP.
REQ-008 SHALL have port TARGET  input  ADDR_WIDTH  jump/branch/call destination.
REQ-009 SHALL have port COND  input  1  branch condition, sampled only for MODE=BRANCH.
REQ-010 SHALL have port OUT  output  ADDR_WIDTH  registered current microaddress.
REQ-011 SHALL have port DEPTH  output  $clog2(STACK_DEPTH+1)  registered count of valid stack entries.
REQ-012 SHALL have port OVERFLOW  output  1  sticky flag: CALL issued with the stack full.
REQ-013 SHALL have port UNDERFLOW  output  1  sticky flag: RET issued with the stack empty.
REQ-014 SHALL have port FAULT  output  1  high while the FSM is in state FAULT.

Function
REQ-015 SHALL implement a two-state FSM: RUN (normal sequencing) and FAULT (frozen after a stack error).
REQ-016 In RUN with ACK=1, SHALL hold OUT, DEPTH, stack contents and flags unchanged, regardless of MODE.
REQ-017 In RUN with ACK=0, MODE=INC, SHALL set OUT <= OUT+1 modulo 2^ADDR_WIDTH (all-ones wraps to 0, no flag).
REQ-018 In RUN with ACK=0, MODE=JUMP, SHALL set OUT <= TARGET.
REQ-019 In RUN with ACK=0, MODE=BRANCH, SHALL set OUT <= TARGET if COND=1, else OUT+1 (wrapping).
REQ-020 In RUN with ACK=0, MODE=CALL and DEPTH<STACK_DEPTH, SHALL push OUT+1 (wrapping), set OUT <= TARGET, and increment DEPTH, all in the same cycle.
REQ-021 In RUN with ACK=0, MODE=CALL and DEPTH=STACK_DEPTH, SHALL leave OUT, DEPTH and the stack unchanged, set OVERFLOW=1, and enter FAULT.
REQ-022 In RUN with ACK=0, MODE=RET and DEPTH>0, SHALL set OUT <= the most recently pushed entry and decrement DEPTH (LIFO).
REQ-023 In RUN with ACK=0, MODE=RET and DEPTH=0, SHALL leave OUT and DEPTH unchanged, set UNDERFLOW=1, and enter FAULT.
REQ-024 In RUN with ACK=0, MODE=NOP (101-111), SHALL hold all state.
REQ-025 In FAULT, SHALL hold OUT, DEPTH, stack and flags, ignoring ACK, MODE, TARGET and COND; only RESET exits FAULT.
REQ-026 Each update SHALL take effect at the clock edge following the command; OUT has exactly one cycle latency from MODE/TARGET/COND.
REQ-027 OVERFLOW and UNDERFLOW SHALL never both be set; each remains set until RESET.

Reset
REQ-028 On a rising CLK edge with RESET=1, SHALL set OUT=RESET_ADDR, DEPTH=0, OVERFLOW=0, UNDERFLOW=0, FAULT=0 and state RUN, overriding ACK and MODE.
REQ-029 Reset SHALL take priority mid-operation, including mid-CALL and in FAULT; stack entry contents need not be cleared, as they are unreachable while DEPTH=0.

Verification
REQ-030 Run INC with ACK=0 from reset (ADDR_WIDTH=11): OUT counts 0,1,2,...,2047,0; hold ACK=1 for 3 cycles at OUT=5 -> OUT stays 5, then resumes at 6.
REQ-031 At OUT=0x010, issue BRANCH TARGET=0x200 with COND=0 -> OUT=0x011; repeat with COND=1 -> OUT=0x200; issue JUMP TARGET=0x7FF, then INC -> OUT=0x000.
REQ-032 Run nested CALLs: at 0x010 CALL 0x100, at 0x100 CALL 0x300, then RET, RET -> OUT sequence 0x100, 0x300, 0x101, 0x011; DEPTH sequence 1, 2, 1, 0.
REQ-033 Issue STACK_DEPTH+1 consecutive CALLs (default 4) -> after the 5th: DEPTH=4, OUT unchanged, OVERFLOW=1, FAULT=1; subsequent INC commands do not change OUT; RESET -> OUT=0, all flags 0.
REQ-034 Issue RET immediately after reset -> UNDERFLOW=1, FAULT=1, OUT=RESET_ADDR held; a CALL issued with ACK=1 while DEPTH=1 -> no push, DEPTH remains 1.
